// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO router: FSM encoding and the default peripheral address map.
package mmio_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StAccess = ACCESS,
        StDone   = DONE
    } state_e;

    // Data memory is the catch-all region, so it carries a zero mask and never hits by decode.
    localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK   = 32'h0000_0000;
    localparam logic [31:0] VGA_BASE    = 32'h1081_0000;
    localparam logic [31:0] VGA_DATA    = 32'h1081_0004;
    localparam logic [31:0] VGA_MASK    = 32'hFFFF_FFF8;
    localparam logic [31:0] SEG7_BASE   = 32'h1001_0000;
    localparam logic [31:0] SEG7_MASK   = 32'hFFFF_FFF0;
    localparam logic [31:0] SWITCH_BASE = 32'h1001_0010;
    localparam logic [31:0] SWITCH_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mmio_if.sv
// CPU data-port bus: request, strobes, address/data, and the registered completion path.
interface mmio_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              m_cs;
    logic              m_we;
    logic              m_re;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport master (
        output m_cs, m_we, m_re, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_cs, m_we, m_re, m_addr, m_wdata,
        output m_rdata, m_ready
    );

endinterface

// File: rtl/mmio_decode.sv
// Combinational base/mask priority matcher; returns the lowest hitting slot or the default slot.
module mmio_decode #(
    parameter int unsigned                  N_SLAVES      = 4,
    parameter int unsigned                  ADDR_W        = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]   BASE          = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0]   MASK          = '0,
    parameter int unsigned                  DEFAULT_SLAVE = 0
) (
    input  logic [ADDR_W-1:0]           addr,
    output logic [$clog2(N_SLAVES)-1:0] sel
);

    localparam int unsigned SEL_W = $clog2(N_SLAVES);

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        sel = SEL_W'(DEFAULT_SLAVE);
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (i != int'(DEFAULT_SLAVE) &&
                MASK[i*ADDR_W +: ADDR_W] != '0 &&
                (addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Routes CPU accesses to one of N_SLAVES peripherals with a ready handshake, bounded wait
// states and a sticky timeout error record.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int unsigned                N_SLAVES      = 4,
    parameter int unsigned                ADDR_W        = 32,
    parameter int unsigned                DATA_W        = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE          = {32'h0, SEG7_BASE, VGA_BASE, DMEM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK          = {32'h0, SEG7_MASK, VGA_MASK, DMEM_MASK},
    parameter int unsigned                DEFAULT_SLAVE = 0,
    parameter int unsigned                TIMEOUT       = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mmio_if.slave                      cpu,
    output logic [N_SLAVES-1:0]        s_cs,
    output logic                       s_we,
    output logic                       s_re,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic                       err,
    output logic [ADDR_W-1:0]          err_addr,
    input  logic                       err_clr
);

    localparam int unsigned SEL_W = $clog2(N_SLAVES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   dec_sel;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic               req;
    logic               rdy;
    logic               cnt_max;
    logic               timeout_hit;
    logic [DATA_W-1:0]  rdata_sel;

    mmio_decode #(
        .N_SLAVES      (N_SLAVES),
        .ADDR_W        (ADDR_W),
        .BASE          (BASE),
        .MASK          (MASK),
        .DEFAULT_SLAVE (DEFAULT_SLAVE)
    ) u_decode (
        .addr (cpu.m_addr),
        .sel  (dec_sel)
    );

    assign req         = cpu.m_cs & (cpu.m_we | cpu.m_re);
    assign rdy         = s_ready[sel];
    assign rdata_sel   = s_rdata[sel*DATA_W +: DATA_W];
    assign cnt_max     = (cnt == CNT_W'(TIMEOUT));
    assign timeout_hit = (state == StAccess) && !rdy && cnt_max;

    assign cpu.m_rdata = rdata_q;
    assign cpu.m_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            sel      <= '0;
            cnt      <= '0;
            s_cs     <= '0;
            s_we     <= 1'b0;
            s_re     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (req) begin
                        sel     <= dec_sel;
                        s_cs    <= N_SLAVES'(1) << dec_sel;
                        s_we    <= cpu.m_we;
                        // A combined strobe is treated as a pure write.
                        s_re    <= cpu.m_re & ~cpu.m_we;
                        s_addr  <= cpu.m_addr;
                        s_wdata <= cpu.m_wdata;
                        cnt     <= '0;
                        state   <= StAccess;
                    end
                end
                StAccess: begin
                    if (rdy) begin
                        if (s_re) begin
                            rdata_q <= rdata_sel;
                        end
                        s_cs    <= '0;
                        ready_q <= 1'b1;
                        state   <= StDone;
                    end else if (cnt_max) begin
                        rdata_q <= '0;
                        s_cs    <= '0;
                        ready_q <= 1'b1;
                        state   <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // A fresh timeout takes priority over a coincident clear.
            if (timeout_hit && (!err || err_clr)) begin
                err      <= 1'b1;
                err_addr <= s_addr;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end
        end
    end

endmodule

// File: doc/mmio_router.md
# mmio_router

Parametrised memory-mapped I/O router between the CPU data port and up to N_SLAVES peripherals (data memory, VGA, seven-segment, switches, Ethernet MAC). It decodes each CPU access against per-slave base/mask pairs and issues exactly one chip-select to the matching slave. It sequences a ready handshake with a bounded wait-state timeout and returns registered read data to the CPU. Unmatched addresses fall through to a default slave, normally data memory.

## Interface
Parameters:
- N_SLAVES, 4, number of slave ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BASE, {32'h10010000, 32'h10810000, 32'h0}, packed N_SLAVES×ADDR_W base addresses; slot i is BASE[i*ADDR_W +: ADDR_W]
- MASK, {32'hFFFFFFF0, 32'hFFFFFFF8, 32'h0}, packed match masks, same layout as BASE
- DEFAULT_SLAVE, 0, slave selected when no region hits
- TIMEOUT, 15, maximum number of ACCESS cycles before an error completion

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_cs  in  1  CPU access request
- m_we  in  1  write strobe
- m_re  in  1  read strobe
- m_addr  in  ADDR_W  access address
- m_wdata  in  DATA_W  write data
- m_rdata  out  DATA_W  registered read data
- m_ready  out  1  completion pulse
- s_cs  out  N_SLAVES  one-hot slave select
- s_we  out  1  latched write strobe
- s_re  out  1  latched read strobe
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_rdata  in  N_SLAVES×DATA_W  packed slave read data
- s_ready  in  N_SLAVES  per-slave completion
- err  out  1  sticky timeout flag
- err_addr  out  ADDR_W  address of the first timed-out access
- err_clr  in  1  synchronous clear of err and err_addr

## Operation
- Decode: hit[i] = ((m_addr & MASK[i]) == BASE[i]) && MASK[i] != 0, for i ≠ DEFAULT_SLAVE. The lowest hitting index wins. If no slot hits, the access goes to DEFAULT_SLAVE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when m_cs && (m_we || m_re):
  - latch sel, addr, wdata, we, re; clear the wait counter; go to ACCESS.
  - If m_we and m_re are both high, the access is a write only (re latched 0).
  - m_cs without either strobe is ignored.
- ACCESS:
  - s_cs[sel] = 1, all other s_cs bits 0.
  - If s_ready[sel] is high: capture s_rdata[sel] into m_rdata (reads only; writes leave m_rdata unchanged), then go to DONE.
  - Otherwise, if the counter equals TIMEOUT: set m_rdata to 0. If err is clear, set err and load err_addr with the latched address. Go to DONE.
  - Otherwise increment the counter.
  - s_ready from unselected slaves is ignored.
- DONE: m_ready = 1 for exactly one cycle, s_cs = 0, then go to IDLE.
- Master contract: hold m_cs and the strobes until m_ready, and deassert them in the m_ready cycle. A request still present in the following IDLE cycle starts a new access.
- err_clr clears err and err_addr. If err_clr and a new timeout occur in the same cycle, the new error wins (set/load).
- Width rule: the counter is $clog2(TIMEOUT+1) bits and never wraps.

## Timing
- Reset values (asynchronous on rst_n low): state IDLE, s_cs 0, s_we/s_re 0, s_addr/s_wdata 0, m_rdata 0, m_ready 0, err 0, err_addr 0, counter 0.
- Latency:
  - Request sampled in IDLE at cycle 0.
  - s_cs asserted at cycle 1.
  - A zero-wait slave (s_ready already high at cycle 1) gives m_ready at cycle 2.
  - Each wait cycle adds 1.
  - Timeout completion gives m_ready at cycle TIMEOUT+2.
- All outputs are registered or decoded from state only; there is no combinational path from m_* or s_ready to any output.
- Reset mid-ACCESS: s_cs drops immediately, no m_ready is issued, and err is unaffected apart from being reset to 0.

## Structure
- Shared package mmio_pkg:
  - state encoding localparams IDLE/ACCESS/DONE
  - default address-map constants for DMEM, VGA (0x10810000/0x10810004), SEG7 (0x10010000), SWITCH (0x10010010)
- Sub-module mmio_decode: combinational base/mask priority matcher. It outputs the selected index and is reusable by a future DMA port.

## Test plan
- Map N_SLAVES=3 (slot 0 DMEM default, slot 1 VGA, slot 2 SEG7); read 0x10810004 with slave 1 ready immediately -> s_cs=3'b010 at cycle 1, m_ready at cycle 2, m_rdata = s_rdata[1].
- Write 0x10010008 with data 0xA5A5A5A5, slave 2 ready after 3 waits -> s_cs=3'b100, s_wdata=0xA5A5A5A5, m_ready at cycle 5, m_rdata unchanged.
- Read 0x00001000 -> default s_cs=3'b001; read 0x10810008 (outside the VGA mask) -> also default.
- Slave 1 never ready, TIMEOUT=15 -> m_ready at cycle 17, m_rdata=0, err=1, err_addr=0x10810000. A second timeout keeps err_addr unchanged. Pulse err_clr -> err=0.
- m_we and m_re both high -> s_we=1, s_re=0. m_cs with no strobe -> stays IDLE, s_cs stays 0.
- Assert rst_n low during ACCESS -> s_cs=0 the same cycle, no m_ready. Next request after reset completes normally.
